fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 58 +++++
 tb/tb_fifo_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Drains a read-latency-1 FIFO into a 2-entry skid buffer and presents a valid/ready stream.
// rd_en to out_valid is 2 cycles; rd_en is held off once buffered plus in-flight words would exceed 2.
module fifo_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    output logic             rd_en,
    input  logic [WIDTH-1:0] rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    logic             w_pop;
    logic             w_cap;
    logic [1:0]       w_occ_after_pop;
    logic [2:0]       w_committed;

    assign w_pop           = out_valid && out_ready;
    assign w_cap           = r_inflight;
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};
    // Words already owned by this block once this cycle's pop leaves.
    assign w_committed     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign rd_en     = !rst && !empty && (w_committed < 3'd2);
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
        end else begin
            r_inflight <= rd_en;
            r_occ      <= w_occ_after_pop + {1'b0, w_cap};
            if (w_pop && (r_occ == 2'd2)) begin
                r_head <= r_tail;
            end
            // Capture lands in the head slot only if the buffer is empty after the pop.
            if (w_cap) begin
                if (w_occ_after_pop == 2'd0) begin
                    r_head <= rd_data;
                end else begin
                    r_tail <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and random checks of fifo_reader against a latency-1 FIFO model and a word-order queue.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty;
    logic       rd_en;
    logic [7:0] rd_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;

    fifo_reader #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // FIFO model: write pointer moved by the stimulus, read pointer by the model.
    logic [7:0] mem [0:1023];
    int         wptr = 0;
    int         rptr = 0;
    int         rd_while_empty = 0;
    logic [7:0] exp_q [$];

    assign empty = (wptr == rptr);

    always @(posedge clk) begin
        if (rd_en && empty) begin
            rd_while_empty <= rd_while_empty + 1;
        end else if (rd_en) begin
            rd_data <= mem[rptr % 1024];
            rptr    <= rptr + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        mem[wptr % 1024] = w;
        wptr++;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        wptr = rptr;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rdy;
        logic       e_rd_en;
        logic       e_valid;
        logic [7:0] e_data;
        logic       chk_data;
    } vec_t;

    vec_t tv [6];

    int pulses;
    int got;
    int bad;
    int cycles;
    int cov_pop;
    int cov_stall2;
    int cov_cap_pop;
    int overflow;
    int mism;
    logic [7:0] w_exp;

    initial begin
        // Basic flow, cycle 0 = first cycle out of reset with 0x11,0x22,0x33 queued.
        tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
        tv[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
        tv[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        // Reset state, with a word available to prove rst blocks rd_en.
        step();
        step();
        push(8'h55);
        @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);

        // Basic flow
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        for (int i = 0; i < 6; i++) begin
            out_ready = tv[i].rdy;
            @(negedge clk);
            check($sformatf("basic_rd_en[%0d]", i), rd_en, tv[i].e_rd_en);
            check($sformatf("basic_valid[%0d]", i), out_valid, tv[i].e_valid);
            if (tv[i].chk_data) check($sformatf("basic_data[%0d]", i), out_data, tv[i].e_data);
            step();
        end

        // Backpressure
        do_reset();
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_en) pulses++;
            step();
        end
        check("bp_rd_pulses", pulses, 2);
        @(negedge clk);
        check("bp_valid_held", out_valid, 1);
        check("bp_data_held", out_data, 8'hA0);
        step();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("bp_order", out_data, 8'hA0 + 8'(got));
                got++;
            end
            step();
        end
        check("bp_count", got, 8);

        // Empty FIFO
        do_reset();
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_en || out_valid) bad++;
            step();
        end
        check("empty_quiet_cycles", bad, 0);

        // Reset while a read is in flight with occ=1
        do_reset();
        push(8'hB0);
        step();
        step();
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        @(negedge clk);
        check("rstmid_rd_en", rd_en, 1);
        check("rstmid_occ1", out_valid, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_rd_en_in_rst", rd_en, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_valid_after", out_valid, 0);
        step();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("rstmid_order", out_data, 8'hB2 + 8'(got));
                got++;
            end
            step();
        end
        check("rstmid_count", got, 2);

        // Throughput
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) push(8'(i + 1));
        got = 0;
        cycles = 0;
        mism = 0;
        for (int c = 0; c < 200 && got < 100; c++) begin
            @(negedge clk);
            if (out_valid) begin
                w_exp = exp_q.pop_front();
                if (out_data !== w_exp) mism++;
                got++;
            end
            cycles = c + 1;
            step();
        end
        check("tp_pops", got, 100);
        check("tp_data_mismatches", mism, 0);
        check("tp_within_102_cycles", (cycles <= 102) ? 1 : 0, 1);

        // Random writes and random out_ready
        do_reset();
        cov_pop = 0;
        cov_stall2 = 0;
        cov_cap_pop = 0;
        overflow = 0;
        mism = 0;
        for (int c = 0; c < 10000; c++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0 && (wptr - rptr) < 500) push(8'($urandom));
            @(negedge clk);
            if (out_valid && out_ready) begin
                cov_pop++;
                if (exp_q.size() == 0) begin
                    mism++;
                end else begin
                    w_exp = exp_q.pop_front();
                    if (out_data !== w_exp) mism++;
                end
                if (dut.r_inflight) cov_cap_pop++;
            end
            if (out_valid && !out_ready && dut.r_occ == 2'd2) cov_stall2++;
            if (32'(dut.r_occ) + 32'(dut.r_inflight) > 2) overflow++;
            step();
        end
        check("rand_data_mismatches", mism, 0);
        check("rand_no_overflow", overflow, 0);
        check("rand_cover_pop", (cov_pop > 0) ? 1 : 0, 1);
        check("rand_cover_stall_occ2", (cov_stall2 > 0) ? 1 : 0, 1);
        check("rand_cover_cap_pop", (cov_cap_pop > 0) ? 1 : 0, 1);
        check("no_read_while_empty", rd_while_empty, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
